// File: rtl/uart_fifo_pkg.sv
// Shared constants and pointer-width helper for the UART RX FIFO slice.
package uart_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // One extra bit above the address distinguishes full from empty on wrap.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_PTR_W = ptr_w(DEF_DEPTH);

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module uart_fifo_ram
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo_param.sv
// Parametrised UART RX byte FIFO with fill count, thresholds, sticky errors and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module uart_rx_fifo_param
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [ptr_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int AW    = PTR_W - 1;
  localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_LVL   = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_LVL   = PTR_W'(AE_THRESH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr, count_r;
  logic [WIDTH-1:0] ram_rdata;
  logic             rd_acc, wr_acc;

  assign full         = (count_r == FULL_LVL);
  assign empty        = (count_r == '0);
  assign almost_full  = (count_r >= AF_LVL);
  assign almost_empty = (count_r <= AE_LVL);
  assign count        = count_r;

  // A same-cycle write never feeds an empty read; a same-cycle read frees a full slot.
  assign rd_acc = rd_en && !empty && !flush;
  assign wr_acc = wr_en && (!full || rd_acc) && !flush;

  uart_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_r   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_r   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_r <= count_r + PTR_W'(1);
        2'b01:   count_r <= count_r - PTR_W'(1);
        default: count_r <= count_r;
      endcase
      if (wr_en && full && !rd_acc) overflow  <= 1'b1;
      if (rd_en && empty)           underflow <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  assign rd_data  = ram_rdata;
  assign rd_valid = !empty;
`else
  logic [WIDTH-1:0] rd_data_p1;
  logic             vld_p1;

  // Output register stage: one cycle read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else if (flush) begin
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) rd_data_p1 <= ram_rdata;
    end
  end

  assign rd_data  = rd_data_p1;
  assign rd_valid = vld_p1;
`endif

endmodule

// File: doc/uart_rx_fifo_param.md
Name: uart_rx_fifo_param

Overview:
Parametrised synchronous FIFO, next generation of the UART RX byte buffer. It sits between the UART receiver (write side) and the host/bus reader (read side). It adds over the previous FIFO:
- configurable width and depth
- correct-polarity full/empty flags
- fill count and almost-full/almost-empty thresholds
- sticky overflow/underflow flags
- synchronous flush
- optional first-word-fall-through read mode

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of pointers, count and sticky flags
wr_en  in  1  write request
wr_data  in  WIDTH  write data
rd_en  in  1  read request (pop in FWFT mode)
rd_data  out  WIDTH  read data
rd_valid  out  1  rd_data holds valid popped/head word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full and not accepted
underflow  out  1  sticky: read attempted while empty and not accepted

Behaviour:
- Reset (reset_n low, asynchronous): wr_ptr=rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=underflow=0. Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0). Storage array is not reset. Reset mid-operation discards all contents.
- Pointers are $clog2(DEPTH)+1 bits; MSB is the wrap bit. full/empty derive from the registered count (or pointer compare; both must agree). Increment wraps naturally modulo 2*DEPTH.
- Write accepted = wr_en && (!full || rd_acc). Data is stored at wr_ptr[addr]; wr_ptr increments.
- Read accepted (rd_acc) = rd_en && !empty. A write in the same cycle never makes an empty FIFO readable.
- Simultaneous accepted read+write: count unchanged.
  - At full: both accepted.
  - At empty: write accepted, read rejected.
- count: +1 on write-only, -1 on read-only, unchanged otherwise. Registered; visible the cycle after the edge.
- Standard mode: on rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 (1-cycle read latency). Otherwise rd_valid <= 0 and rd_data holds its last value.
- overflow sets on wr_en && full && !rd_acc. underflow sets on rd_en && empty. Both stay set until flush or reset.
- flush: highest synchronous priority; same-cycle wr/rd ignored. Pointers, count, rd_valid and sticky flags clear; rd_data holds.
- Flags are a combinational function of registered count; no glitch-free requirement beyond that.

Optional Feature:
Macro FIFO_FWFT_EN.
- Defined: first-word-fall-through mode. rd_data = mem[rd_ptr] combinationally and rd_valid = !empty.
  - rd_en acts as pop/ack of the displayed word; no extra latency.
  - A word written into an empty FIFO appears on rd_data/rd_valid the cycle after the write edge.
  - underflow rule is unchanged.
- Undefined: standard registered-read behaviour as above.

Decomposition:
- Package uart_fifo_pkg: default WIDTH/DEPTH constants, and a pointer-width localparam helper (PTR_W = $clog2(DEPTH)+1).
- Sub-module uart_fifo_ram: simple dual-port array with synchronous write and asynchronous read, parametrised by WIDTH/DEPTH. The top level holds pointers, count, flags and the output register.

Test Plan:
- Reset/basic: release reset_n, write 0x11,0x22,0x33, then read 3 -> standard mode: rd_data 0x11,0x22,0x33, each rd_valid one cycle after rd_en. count 3->0, empty=1 at end.
- Fill/overflow: write 17 words 0x00..0x10 (DEPTH=16) -> full=1 after 16th, 17th dropped, overflow=1 sticky. Drain returns 0x00..0x0F.
- Wrap-around: 40 interleaved write/read ops of incrementing data -> data order preserved across pointer wrap, no spurious full/empty.
- Simultaneous at boundaries:
  - At full, wr+rd same cycle -> both accepted, count stays 16.
  - At empty, wr+rd -> count 1, underflow=1, rd_valid=0.
- Thresholds/flush: fill to 14 -> almost_full=1. Flush with wr_en high -> count 0, empty=1, overflow/underflow cleared, written word discarded.
- FWFT (FIFO_FWFT_EN): write 0xA5 into empty -> next cycle rd_valid=1, rd_data=0xA5 without rd_en. Pulse rd_en -> empty=1 next cycle.
